// File: rtl/div_const_pkg.sv
// Shared constants, FSM state type and step-count helpers for the
// chunked constant-division controller and its datapath.
package div_const_pkg;

  localparam int DATA_W_DEF  = 64;
  localparam int DIGIT_W_DEF = 4;
  localparam int DIVISOR_DEF = 23;
  localparam int REM_W_DEF   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int n_steps(input int data_w, input int digit_w);
    return data_w / digit_w;
  endfunction

  // Counter width for 0..n_steps-1, never narrower than one bit.
  function automatic int cnt_w(input int data_w, input int digit_w);
    int n;
    n = n_steps(data_w, digit_w);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_const_step.sv
// One long-division step by a constant: {rem_in, chunk} / DIVISOR.
// Purely combinational; shared with the unrolled datapath.
module div_const_step
  import div_const_pkg::*;
#(
  parameter int DIGIT_W = DIGIT_W_DEF,
  parameter int REM_W   = REM_W_DEF,
  parameter int DIVISOR = DIVISOR_DEF
) (
  input  logic [REM_W-1:0]   rem_in,
  input  logic [DIGIT_W-1:0] chunk,
  output logic [DIGIT_W-1:0] digit,
  output logic [REM_W-1:0]   rem_out,
  output logic               digit_ovf
);

  localparam int T_W = REM_W + DIGIT_W;
  localparam logic [T_W-1:0] DIV_T = T_W'(DIVISOR);

  logic [T_W-1:0] t;
  logic [T_W-1:0] q_full;

  always_comb begin
    t         = {rem_in, chunk};
    q_full    = t / DIV_T;
    digit     = q_full[DIGIT_W-1:0];
    rem_out   = REM_W'(t % DIV_T);
    // Only reachable if rem_in >= DIVISOR, which the controller never feeds.
    digit_ovf = |(q_full >> DIGIT_W);
  end

endmodule

// File: rtl/div23_seq_ctrl.sv
// Sequential divide-by-constant: one DIGIT_W chunk per cycle, MSB first,
// with valid/ready handshakes on dividend input and result output.
module div23_seq_ctrl
  import div_const_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DIGIT_W = DIGIT_W_DEF,
  parameter int DIVISOR = DIVISOR_DEF,
  parameter int REM_W   = REM_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_quot,
  output logic [REM_W-1:0]  out_rem,
  output logic              busy
);

  localparam int N_STEPS = n_steps(DATA_W, DIGIT_W);
  localparam int CNT_W   = cnt_w(DATA_W, DIGIT_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_STEPS - 1);

  state_t             state_reg, state_next;
  logic [DATA_W-1:0]  shift_reg;
  logic [DATA_W-1:0]  quot_acc_reg;
  logic [DATA_W-1:0]  out_quot_reg;
  logic [REM_W-1:0]   rem_reg;
  logic [REM_W-1:0]   out_rem_reg;
  logic [CNT_W-1:0]   cnt_reg;

  logic [DIGIT_W-1:0] step_digit;
  logic [REM_W-1:0]   step_rem;
  logic               step_ovf;
  logic [DATA_W-1:0]  quot_next;
  logic               accept;
  logic               stepping;

  div_const_step #(
    .DIGIT_W (DIGIT_W),
    .REM_W   (REM_W),
    .DIVISOR (DIVISOR)
  ) u_step (
    .rem_in    (rem_reg),
    .chunk     (shift_reg[DATA_W-1 -: DIGIT_W]),
    .digit     (step_digit),
    .rem_out   (step_rem),
    .digit_ovf (step_ovf)
  );

  // flush outranks everything, including a same-cycle accept in IDLE.
  assign accept    = (state_reg == IDLE) && in_valid && !flush;
  assign stepping  = (state_reg == RUN) && !flush;
  assign quot_next = (quot_acc_reg << DIGIT_W) | DATA_W'(step_digit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (flush)                    state_next = IDLE;
        else if (cnt_reg == LAST_CNT) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (flush || out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg    <= '0;
      quot_acc_reg <= '0;
      rem_reg      <= '0;
      cnt_reg      <= '0;
      out_quot_reg <= '0;
      out_rem_reg  <= '0;
    end else if (accept) begin
      shift_reg    <= in_data;
      quot_acc_reg <= '0;
      rem_reg      <= '0;
      cnt_reg      <= '0;
    end else if (stepping) begin
      assert (!step_ovf);
      shift_reg    <= shift_reg << DIGIT_W;
      quot_acc_reg <= quot_next;
      rem_reg      <= step_rem;
      cnt_reg      <= cnt_reg + CNT_W'(1);
      // Result registers only move on the final step, so DONE holds them stable.
      if (cnt_reg == LAST_CNT) begin
        out_quot_reg <= quot_next;
        out_rem_reg  <= step_rem;
      end
    end
  end

  assign out_quot = out_quot_reg;
  assign out_rem  = out_rem_reg;

endmodule

// File: tb/tb_div23_seq_ctrl.sv
// Directed + random checks of div23_seq_ctrl against a 64-bit / and % model.
module tb_div23_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_quot;
  logic [4:0]  out_rem;
  logic        busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] q;
    logic [4:0]  r;
  } exp_t;
  exp_t sb[$];

  logic [63:0] last_q = '0;

  div23_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_quot  (out_quot),
    .out_rem   (out_rem),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves with the dividend accepted and time in RUN step 0.
  task automatic accept(input logic [63:0] d);
    exp_t e;
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", in_ready, 1);
    e.q = d / 64'd23;
    e.r = 5'(d % 64'd23);
    sb.push_back(e);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    $display("accept dividend=%0d", d);
  endtask

  task automatic wait_done(input string tag);
    int n;
    int bad;
    n = 1;
    bad = 0;
    while (!out_valid && n < 60) begin
      if (in_ready) bad++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, out_valid, 1);
    chk({tag, "_latency"}, n, 17);
    chk({tag, "_in_ready_low"}, bad, 0);
  endtask

  task automatic take(input string tag);
    exp_t e;
    out_ready = 1'b1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, sb.size(), 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_quot"}, out_quot, e.q);
      chk({tag, "_rem"}, out_rem, 64'(e.r));
      $display("result %s quot=%0d rem=%0d exp_quot=%0d exp_rem=%0d", tag, out_quot, out_rem, e.q, e.r);
    end
    last_q = out_quot;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_ready_back"}, in_ready, 1);
  endtask

  task automatic run_one(input logic [63:0] d, input string tag);
    accept(d);
    wait_done(tag);
    take(tag);
  endtask

  initial begin
    int vcnt;
    logic [63:0] held_q;
    logic [63:0] d;

    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_quot", out_quot, 0);
    chk("rst_rem", out_rem, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_one(64'd1000, "d1000");
    run_one(64'd22, "d22");
    run_one(64'd23, "d23");
    run_one(64'd0, "d0");
    run_one(64'hFFFF_FFFF_FFFF_FFFF, "dmax");
    chk("dmax_quot_const", last_q, 64'd802032351030850070);

    // Back-pressure: DONE holds, in_valid ignored
    accept(64'd500);
    wait_done("bp");
    held_q   = out_quot;
    in_valid = 1'b1;
    in_data  = 64'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid_hold", out_valid, 1);
      chk("bp_quot_stable", out_quot, held_q);
      chk("bp_in_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    take("bp");
    run_one(64'd777, "after_bp");

    // Flush at RUN step 7
    accept(64'd999);
    repeat (7) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_run_busy", busy, 0);
    chk("flush_run_in_ready", in_ready, 1);
    chk("flush_run_quot_kept", out_quot, last_q);
    void'(sb.pop_back());
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) vcnt++;
      @(negedge clk);
    end
    chk("flush_run_no_valid", vcnt, 0);
    $display("flush in RUN step 7 done");
    run_one(64'd46, "d46");

    // Flush in IDLE blocks a simultaneous accept
    in_valid = 1'b1;
    in_data  = 64'd5;
    flush    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush_idle_busy", busy, 0);
    $display("flush in IDLE done");

    // Flush together with out_ready in DONE
    accept(64'd12345);
    wait_done("fd");
    flush     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    out_ready = 1'b0;
    chk("flush_done_valid", out_valid, 0);
    chk("flush_done_busy", busy, 0);
    chk("flush_done_quot", out_quot, 64'd12345 / 64'd23);
    void'(sb.pop_back());
    $display("flush in DONE done");

    // Asynchronous reset mid-RUN
    accept(64'd123456);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_quot", out_quot, 0);
    chk("arst_rem", out_rem, 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("async reset mid-RUN done");

    // Random dividends, random back-pressure
    for (int i = 0; i < 8; i++) begin
      d = {$urandom(), $urandom()};
      accept(d);
      wait_done("rnd");
      held_q = out_quot;
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("rnd_hold_valid", out_valid, 1);
        chk("rnd_hold_quot", out_quot, held_q);
      end
      take("rnd");
    end
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
